// File: rtl/stepper_sequencer.sv
// rtl/stepper_sequencer.sv - command-driven 4-wire stepper phase sequencer
//
// Purpose:
//   Accepts a move command (direction, step count) through a valid/ready
//   handshake. It steps the coil phase pattern once every STEP_DIV clocks,
//   keeps a signed absolute position, and pulses done when the move ends,
//   whether it completed or was aborted.
//
// Optional feature:
//   STEPPER_HALF_STEP_EN - when defined, the 8-entry half-step table is used
//   and the phase index is 3 bits wide. When undefined, the 4-entry full-step
//   table is used and the phase index is 2 bits wide.
//
// Ports:
//   clock       in   1      system clock
//   reset       in   1      synchronous, active-high
//   cmd_valid   in   1      move command present
//   cmd_ready   out  1      command accepted when high (IDLE only)
//   cmd_dir     in   1      1 = forward (phase +1), 0 = reverse (phase -1)
//   cmd_steps   in   CNT_W  number of steps to take
//   abort       in   1      stop the current move (honoured in RUN only)
//   coil        out  4      coil drive {A,B,C,D}
//   busy        out  1      high while a move is running
//   done        out  1      one-cycle pulse at the end of a move
//   steps_left  out  CNT_W  steps remaining in the current or last move
//   position    out  32     signed absolute step count

module stepper_sequencer #(
  parameter int unsigned STEP_DIV = 50000,
  parameter int unsigned DIV_W    = 20,
  parameter int unsigned CNT_W    = 16,
  parameter bit          HOLD     = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             abort,
  output logic [3:0]       coil,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left,
  output logic [31:0]      position
);

`ifdef STEPPER_HALF_STEP_EN
  localparam int unsigned PH_W = 3;
`else
  localparam int unsigned PH_W = 2;
`endif

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [3:0]         coil_q, coil_d;
  logic [CNT_W-1:0]   steps_left_q, steps_left_d;
  logic [31:0]        position_q, position_d;
  logic               dir_q, dir_d;

  // The phase index is a power-of-two width, so +/-1 wraps around the table
  // naturally (3->0 / 0->3 full-step, 7->0 / 0->7 half-step).
  function automatic logic [3:0] coil_lut(input logic [PH_W-1:0] ph);
    logic [3:0] pat;
    pat = 4'b0000;
`ifdef STEPPER_HALF_STEP_EN
    case (ph)
      3'd0: pat = 4'b1000;
      3'd1: pat = 4'b1100;
      3'd2: pat = 4'b0100;
      3'd3: pat = 4'b0110;
      3'd4: pat = 4'b0010;
      3'd5: pat = 4'b0011;
      3'd6: pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
`else
    case (ph)
      2'd0: pat = 4'b1001;
      2'd1: pat = 4'b1100;
      2'd2: pat = 4'b0110;
      default: pat = 4'b0011;
    endcase
`endif
    return pat;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      phase_q      <= '0;
      coil_q       <= 4'b0000;
      steps_left_q <= '0;
      position_q   <= '0;
      dir_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      phase_q      <= phase_d;
      coil_q       <= coil_d;
      steps_left_q <= steps_left_d;
      position_q   <= position_d;
      dir_q        <= dir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    phase_d      = phase_q;
    coil_d       = coil_q;
    steps_left_d = steps_left_q;
    position_d   = position_q;
    dir_d        = dir_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dir_d        = cmd_dir;
          steps_left_d = cmd_steps;
          div_d        = '0;
          state_d      = (cmd_steps == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          // Abort wins over a coincident step; the remaining count is kept.
          state_d = S_DONE;
        end else if (steps_left_q == '0) begin
          // The last step landed on the previous edge; finish one cycle later.
          state_d = S_DONE;
        end else if (div_q == DIV_LAST) begin
          div_d        = '0;
          phase_d      = dir_q ? (phase_q + 1'b1) : (phase_q - 1'b1);
          coil_d       = coil_lut(phase_d);
          steps_left_d = steps_left_q - 1'b1;
          position_d   = dir_q ? (position_q + 32'd1) : (position_q - 32'd1);
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign steps_left = steps_left_q;
  assign position   = position_q;
  // coil_q is zero from reset until the first step, so HOLD=1 idles at 0 too.
  assign coil       = ((state_q == S_IDLE) && !HOLD) ? 4'b0000 : coil_q;

endmodule

// File: tb/tb_stepper_sequencer.sv
// tb/tb_stepper_sequencer.sv - directed self-checking bench for stepper_sequencer

module tb_stepper_sequencer;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic        abort;
  logic [3:0]  coil;
  logic        busy;
  logic        done;
  logic [15:0] steps_left;
  logic [31:0] position;

  int total = 0;
  int bad   = 0;

  stepper_sequencer #(
    .STEP_DIV (4),
    .DIV_W    (20),
    .CNT_W    (16),
    .HOLD     (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .abort      (abort),
    .coil       (coil),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left),
    .position   (position)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command for exactly one edge; returns just after the handshake edge.
  task automatic go(input logic dir, input logic [15:0] steps);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = steps;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  logic [3:0] rev_exp  [5];
  logic [3:0] half_exp [8];

  initial begin
    rev_exp  = '{4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011};
    half_exp = '{4'b1100, 4'b0100, 4'b0110, 4'b0010,
                 4'b0011, 4'b0001, 4'b1001, 4'b1000};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = '0;
    abort     = 1'b0;
    tick(2);

    chk("rst_coil",       32'(coil),       32'h0);
    chk("rst_ready",      32'(cmd_ready),  32'h1);
    chk("rst_busy",       32'(busy),       32'h0);
    chk("rst_done",       32'(done),       32'h0);
    chk("rst_steps_left", 32'(steps_left), 32'h0);
    chk("rst_position",   position,        32'h0);
    reset = 1'b0;

`ifdef STEPPER_HALF_STEP_EN
    go(1'b1, 16'd8);
    for (int i = 0; i < 8; i++) begin
      tick(4);
      chk($sformatf("half_coil%0d", i), 32'(coil), 32'(half_exp[i]));
    end
    chk("half_position", position, 32'd8);
    tick(1);
    chk("half_done", 32'(done), 32'h1);
    tick(1);
    chk("half_hold_coil", 32'(coil), 32'b1000);
`else
    // Forward 3 steps from reset.
    go(1'b1, 16'd3);
    chk("f3_busy",       32'(busy),       32'h1);
    chk("f3_ready",      32'(cmd_ready),  32'h0);
    chk("f3_steps_left", 32'(steps_left), 32'd3);
    tick(3);
    chk("f3_coil_k3", 32'(coil), 32'h0);
    tick(1);
    chk("f3_coil_k4", 32'(coil), 32'b1100);
    chk("f3_pos_k4",  position,  32'd1);
    tick(4);
    chk("f3_coil_k8", 32'(coil), 32'b0110);
    tick(4);
    chk("f3_coil_k12",  32'(coil),       32'b0011);
    chk("f3_left_k12",  32'(steps_left), 32'd0);
    chk("f3_done_k12",  32'(done),       32'h0);
    tick(1);
    chk("f3_done_k13",  32'(done),      32'h1);
    chk("f3_ready_k13", 32'(cmd_ready), 32'h0);
    chk("f3_busy_k13",  32'(busy),      32'h0);
    tick(1);
    chk("f3_done_k14",  32'(done),      32'h0);
    chk("f3_ready_k14", 32'(cmd_ready), 32'h1);
    chk("f3_hold_coil", 32'(coil),      32'b0011);
    chk("f3_position",  position,       32'd3);

    // Reverse 5 from phase 0, wrapping 0->3.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    go(1'b0, 16'd5);
    for (int i = 0; i < 5; i++) begin
      tick(4);
      chk($sformatf("r5_coil%0d", i), 32'(coil), 32'(rev_exp[i]));
    end
    chk("r5_position", position, 32'hFFFF_FFFB);
    tick(1);
    chk("r5_done", 32'(done), 32'h1);
    tick(1);
    chk("r5_ready", 32'(cmd_ready), 32'h1);

    // Zero-step command: done next cycle, nothing moves.
    go(1'b1, 16'd0);
    chk("z_done",  32'(done),      32'h1);
    chk("z_busy",  32'(busy),      32'h0);
    chk("z_coil",  32'(coil),      32'b0011);
    chk("z_pos",   position,       32'hFFFF_FFFB);
    tick(1);
    chk("z_done_off", 32'(done),      32'h0);
    chk("z_ready",    32'(cmd_ready), 32'h1);

    // Abort on the cycle of the 3rd step (phase starts at 3).
    go(1'b1, 16'd10);
    tick(4);
    chk("ab_coil1", 32'(coil), 32'b1001);
    tick(4);
    chk("ab_coil2", 32'(coil), 32'b1100);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("ab_done", 32'(done),       32'h1);
    chk("ab_left", 32'(steps_left), 32'd8);
    chk("ab_coil", 32'(coil),       32'b1100);
    chk("ab_pos",  position,        32'hFFFF_FFFD);
    tick(1);
    chk("ab_done_off", 32'(done),      32'h0);
    chk("ab_ready",    32'(cmd_ready), 32'h1);

    // Abort in IDLE is ignored.
    abort = 1'b1;
    tick(2);
    abort = 1'b0;
    chk("ab_idle_busy", 32'(busy), 32'h0);
    chk("ab_idle_done", 32'(done), 32'h0);
    chk("ab_idle_left", 32'(steps_left), 32'd8);

    // cmd_valid held with new steps during RUN, then reset mid-move.
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 16'd2;
    tick(1);
    cmd_steps = 16'd7;
    tick(4);
    chk("hv_left", 32'(steps_left), 32'd1);
    chk("hv_coil", 32'(coil),       32'b0110);
    tick(2);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    tick(1);
    reset = 1'b0;
    chk("mr_coil",  32'(coil),       32'h0);
    chk("mr_pos",   position,        32'h0);
    chk("mr_left",  32'(steps_left), 32'h0);
    chk("mr_busy",  32'(busy),       32'h0);
    chk("mr_ready", 32'(cmd_ready),  32'h1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mr_no_done%0d", i), 32'(done), 32'h0);
      tick(1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
